// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Groups the pipeline-side signals seen by the hazard/stall controller.
//   master : pipeline side; drives hazard sources, receives controls/counters.
//   slave  : the controller; receives hazard sources, drives controls/counters.
// Parameter CW sets the width of the stall/flush performance counters.
interface hazard_ctrl_if #(
   parameter int unsigned CW = 32
) ();
   logic [4:0]    Rs1_id;
   logic [4:0]    Rs2_id;
   logic          rs1_used_id;
   logic          rs2_used_id;
   logic [4:0]    Rd_id_ex;
   logic          MemRead_id_ex;
   logic          jump_flag;
   logic          mem_req;
   logic          mem_ready;
   logic          pc_hold;
   logic          if_id_hold;
   logic          if_id_flush;
   logic          load_use_flag;
   logic          id_ex_hold;
   logic          ex_mem_hold;
   logic          mem_wb_bubble;
   logic          mem_err;
   logic          wait_state;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   modport master (
      output Rs1_id, Rs2_id, rs1_used_id, rs2_used_id, Rd_id_ex, MemRead_id_ex,
             jump_flag, mem_req, mem_ready,
      input  pc_hold, if_id_hold, if_id_flush, load_use_flag, id_ex_hold, ex_mem_hold,
             mem_wb_bubble, mem_err, wait_state, stall_cnt, flush_cnt
   );

   modport slave (
      input  Rs1_id, Rs2_id, rs1_used_id, rs2_used_id, Rd_id_ex, MemRead_id_ex,
             jump_flag, mem_req, mem_ready,
      output pc_hold, if_id_hold, if_id_flush, load_use_flag, id_ex_hold, ex_mem_hold,
             mem_wb_bubble, mem_err, wait_state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hold/flush/bubble controller for the 5-stage RV32I pipeline. Handles load-use
// hazards, taken jumps/branches resolved in EX and multi-cycle data-memory
// accesses (with a timeout watchdog), and keeps saturating stall/flush counters.
// Ports:
//   clk   : core clock, rising edge
//   rst   : asynchronous active-high reset
//   io_hz : hazard_ctrl_if.slave - hazard sources in, pipeline controls and
//           performance counters out
// Parameters:
//   TIMEOUT : max consecutive memory-wait freeze cycles (1..255)
//   CW      : performance counter width (must match the interface CW)
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 32
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave io_hz
);
   typedef enum logic {StRun = 1'b0, StWait = 1'b1} state_e;

   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

   state_e        r_state, w_state_d;
   logic [7:0]    r_wait_cnt, w_wait_cnt_d;
   logic [CW-1:0] r_stall_cnt, w_stall_cnt_d;
   logic [CW-1:0] r_flush_cnt, w_flush_cnt_d;

   logic w_lu, w_frz, w_timeout;
   logic w_pc_hold, w_if_id_hold, w_if_id_flush, w_load_use;
   logic w_id_ex_hold, w_ex_mem_hold, w_mem_wb_bubble, w_mem_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StRun;
         r_wait_cnt  <= 8'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_wait_cnt  <= w_wait_cnt_d;
         r_stall_cnt <= w_stall_cnt_d;
         r_flush_cnt <= w_flush_cnt_d;
      end
   end

   always_comb begin
      w_lu = io_hz.MemRead_id_ex && (io_hz.Rd_id_ex != 5'd0) &&
             ((io_hz.rs1_used_id && (io_hz.Rs1_id == io_hz.Rd_id_ex)) ||
              (io_hz.rs2_used_id && (io_hz.Rs2_id == io_hz.Rd_id_ex)));
      // Once the wait counter hits TIMEOUT the freeze is released and the
      // access is abandoned with a one-cycle error pulse.
      w_frz     = io_hz.mem_req && !io_hz.mem_ready && (r_wait_cnt != TimeoutVal);
      w_timeout = io_hz.mem_req && !io_hz.mem_ready && (r_wait_cnt == TimeoutVal);

      w_pc_hold       = 1'b0;
      w_if_id_hold    = 1'b0;
      w_if_id_flush   = 1'b0;
      w_load_use      = 1'b0;
      w_id_ex_hold    = 1'b0;
      w_ex_mem_hold   = 1'b0;
      w_mem_wb_bubble = 1'b0;
      w_mem_err       = 1'b0;

      if (!rst) begin
         w_mem_err = w_timeout;
         // Freeze wins: any jump/load-use is re-seen once the freeze lifts,
         // since ID and EX are held unchanged.
         if (w_frz) begin
            w_pc_hold       = 1'b1;
            w_if_id_hold    = 1'b1;
            w_id_ex_hold    = 1'b1;
            w_ex_mem_hold   = 1'b1;
            w_mem_wb_bubble = 1'b1;
         end else if (io_hz.jump_flag) begin
            // ID instruction is discarded, so a coincident load-use is moot.
            w_if_id_flush = 1'b1;
            w_load_use    = 1'b1;
         end else if (w_lu) begin
            w_load_use   = 1'b1;
            w_pc_hold    = 1'b1;
            w_if_id_hold = 1'b1;
         end
      end

      w_state_d    = w_frz ? StWait : StRun;
      w_wait_cnt_d = w_frz ? (r_wait_cnt + 8'd1) : 8'd0;

      w_stall_cnt_d = r_stall_cnt;
      if (w_pc_hold && (r_stall_cnt != {CW{1'b1}})) begin
         w_stall_cnt_d = r_stall_cnt + 1'b1;
      end
      w_flush_cnt_d = r_flush_cnt;
      if (w_if_id_flush && (r_flush_cnt != {CW{1'b1}})) begin
         w_flush_cnt_d = r_flush_cnt + 1'b1;
      end
   end

   assign io_hz.pc_hold       = w_pc_hold;
   assign io_hz.if_id_hold    = w_if_id_hold;
   assign io_hz.if_id_flush   = w_if_id_flush;
   assign io_hz.load_use_flag = w_load_use;
   assign io_hz.id_ex_hold    = w_id_ex_hold;
   assign io_hz.ex_mem_hold   = w_ex_mem_hold;
   assign io_hz.mem_wb_bubble = w_mem_wb_bubble;
   assign io_hz.mem_err       = w_mem_err;
   assign io_hz.wait_state    = (r_state == StWait);
   assign io_hz.stall_cnt     = r_stall_cnt;
   assign io_hz.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl, built with TIMEOUT=4 and CW=4 so the
// timeout and counter saturation are reachable in a few cycles.
module tb_hazard_ctrl;
   // Control vector bit order:
   // {pc_hold, if_id_hold, if_id_flush, load_use_flag,
   //  id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_err}
   localparam logic [7:0] CIdle = 8'b0000_0000;
   localparam logic [7:0] CLu   = 8'b1101_0000;
   localparam logic [7:0] CJmp  = 8'b0011_0000;
   localparam logic [7:0] CFrz  = 8'b1100_1110;
   localparam logic [7:0] CErr  = 8'b0000_0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   hazard_ctrl_if #(.CW(4)) hz ();

   hazard_ctrl #(
      .TIMEOUT(4),
      .CW     (4)
   ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .io_hz(hz)
   );

   logic [7:0] ctl;
   assign ctl = {hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.load_use_flag,
                 hz.id_ex_hold, hz.ex_mem_hold, hz.mem_wb_bubble, hz.mem_err};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      hz.Rs1_id        = 5'd0;
      hz.Rs2_id        = 5'd0;
      hz.rs1_used_id   = 1'b0;
      hz.rs2_used_id   = 1'b0;
      hz.Rd_id_ex      = 5'd0;
      hz.MemRead_id_ex = 1'b0;
      hz.jump_flag     = 1'b0;
      hz.mem_req       = 1'b0;
      hz.mem_ready     = 1'b0;
   endtask

   // Called just after a falling edge with inputs already set: check the
   // combinational controls (and wait_state unless exp_ws < 0), then advance.
   task automatic cyc(input string tag, input logic [7:0] exp_ctl, input int exp_ws);
      #1;
      check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
      if (exp_ws >= 0) check({tag, "_ws"}, 32'(hz.wait_state), 32'(exp_ws));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_cnt(input string tag, input int exp_stall, input int exp_flush);
      check({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(exp_stall));
      check({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(exp_flush));
   endtask

   initial begin
      // Reset with hazards present: controls must still be zero.
      clr_in();
      hz.jump_flag     = 1'b1;
      hz.mem_req       = 1'b1;
      hz.MemRead_id_ex = 1'b1;
      hz.Rd_id_ex      = 5'd5;
      hz.Rs1_id        = 5'd5;
      hz.rs1_used_id   = 1'b1;
      #3;
      check("rst_ctl", 32'(ctl), 32'(CIdle));
      check("rst_ws", 32'(hz.wait_state), 32'd0);
      check_cnt("rst", 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clr_in();

      // Load-use on rs2, then bubble clears it.
      hz.MemRead_id_ex = 1'b1; hz.Rd_id_ex = 5'd5; hz.Rs2_id = 5'd5; hz.rs2_used_id = 1'b1;
      cyc("lu_rs2", CLu, 0);
      hz.MemRead_id_ex = 1'b0;
      cyc("lu_after", CIdle, 0);
      check_cnt("lu", 1, 0);

      // x0 destination and unused operand never stall.
      clr_in();
      hz.MemRead_id_ex = 1'b1; hz.Rd_id_ex = 5'd0; hz.Rs1_id = 5'd0; hz.rs1_used_id = 1'b1;
      cyc("lu_x0", CIdle, 0);
      hz.Rd_id_ex = 5'd5; hz.Rs1_id = 5'd5; hz.rs1_used_id = 1'b0;
      cyc("lu_unused", CIdle, 0);
      hz.rs1_used_id = 1'b1; hz.MemRead_id_ex = 1'b0;
      cyc("lu_noload", CIdle, 0);
      hz.MemRead_id_ex = 1'b1;
      cyc("lu_rs1", CLu, 0);

      // Jump wins over simultaneous load-use.
      hz.jump_flag = 1'b1;
      cyc("jmp_lu", CJmp, 0);
      check_cnt("jmp", 2, 1);

      // 3-cycle memory wait with a jump pending throughout.
      clr_in();
      hz.mem_req = 1'b1; hz.jump_flag = 1'b1;
      cyc("mw1", CFrz, 0);
      cyc("mw2", CFrz, 1);
      cyc("mw3", CFrz, 1);
      hz.mem_ready = 1'b1;
      cyc("mw4", CJmp, -1);
      clr_in();
      cyc("mw5", CIdle, 0);
      check_cnt("mw", 5, 2);

      // Timeout: 4 freeze cycles then one error cycle without freeze.
      hz.mem_req = 1'b1;
      cyc("to1", CFrz, 0);
      cyc("to2", CFrz, 1);
      cyc("to3", CFrz, 1);
      cyc("to4", CFrz, 1);
      cyc("to_err", CErr, -1);
      clr_in();
      cyc("to_after", CIdle, 0);
      check_cnt("to", 9, 2);

      // Asynchronous reset in the middle of a wait.
      hz.mem_req = 1'b1;
      cyc("rw1", CFrz, 0);
      cyc("rw2", CFrz, 1);
      rst = 1'b1;
      #1;
      check("rw_rst_ctl", 32'(ctl), 32'(CIdle));
      check("rw_rst_ws", 32'(hz.wait_state), 32'd0);
      check_cnt("rw_rst", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      clr_in();
      cyc("rw_idle", CIdle, 0);
      hz.mem_req = 1'b1;
      cyc("rw_new1", CFrz, 0);
      cyc("rw_new2", CFrz, 1);
      hz.mem_ready = 1'b1;
      cyc("rw_new3", CIdle, -1);
      clr_in();
      check_cnt("rw_new", 2, 0);

      // Counter saturation at 15 (CW=4).
      hz.MemRead_id_ex = 1'b1; hz.Rd_id_ex = 5'd7; hz.Rs1_id = 5'd7; hz.rs1_used_id = 1'b1;
      for (int i = 0; i < 15; i++) cyc("sat_lu", CLu, 0);
      check("sat_stall_cnt", 32'(hz.stall_cnt), 32'd15);
      clr_in();
      hz.jump_flag = 1'b1;
      for (int i = 0; i < 16; i++) cyc("sat_jmp", CJmp, 0);
      check_cnt("sat", 15, 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It generates the hold, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases: load-use hazards, taken jumps/branches resolved in EX, and multi-cycle data-memory accesses, with a timeout watchdog on the memory wait. Its `load_use_flag` output feeds the ID/EX register's bubble input. It also keeps saturating stall and flush performance counters.

## Interface
- `TIMEOUT`, 255: maximum consecutive memory-wait freeze cycles; legal range 1..255.
- `CW`, 32: performance counter width.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: reset; one clock; reset is asynchronous and active-high.
- `Rs1_id`, `Rs2_id` input 5: source registers of the instruction in ID.
- `rs1_used_id`, `rs2_used_id` input 1: the instruction in ID actually reads Rs1/Rs2.
- `Rd_id_ex` input 5: destination of the instruction in EX.
- `MemRead_id_ex` input 1: the instruction in EX is a load.
- `jump_flag` input 1: taken branch, jal or jalr resolved in EX this cycle.
- `mem_req` input 1: the instruction in MEM performs a load or store.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_hold` output 1: PC keeps its value.
- `if_id_hold` output 1: IF/ID keeps its value.
- `if_id_flush` output 1: IF/ID loads a NOP.
- `load_use_flag` output 1: ID/EX loads a bubble (controls zeroed).
- `id_ex_hold`, `ex_mem_hold` output 1: the register keeps its value.
- `mem_wb_bubble` output 1: MEM/WB loads a bubble (RegWrite=0).
- `mem_err` output 1: one-cycle pulse when a memory wait times out.
- `wait_state` output 1: FSM is in WAIT.
- `stall_cnt` output CW: count of cycles with `pc_hold`=1.
- `flush_cnt` output CW: count of cycles with `if_id_flush`=1.

## Operation
- Load-use hazard `lu` is 1 when all of the following hold:
  - `MemRead_id_ex` = 1 and `Rd_id_ex` != 0;
  - (`rs1_used_id` and `Rs1_id` == `Rd_id_ex`) or (`rs2_used_id` and `Rs2_id` == `Rd_id_ex`).
- Memory freeze: `frz` = `mem_req` & !`mem_ready` & (`wait_cnt` != `TIMEOUT`).
- Priority is freeze > jump > load-use.
- On freeze (`frz`=1):
  - `pc_hold`, `if_id_hold`, `id_ex_hold`, `ex_mem_hold` and `mem_wb_bubble` = 1.
  - `if_id_flush` and `load_use_flag` = 0.
  - A jump or load-use condition present during the freeze is deferred. EX and ID are frozen, so it is re-evaluated and acted on in the first unfrozen cycle.
- On jump (!`frz` & `jump_flag`):
  - `if_id_flush` = 1 and `load_use_flag` = 1 (the ID/EX bubble).
  - `pc_hold` = 0, so the PC takes the target.
  - A simultaneous `lu` is ignored, because the ID instruction is discarded.
- On load-use only (!`frz` & !`jump_flag` & `lu`): `load_use_flag`, `pc_hold` and `if_id_hold` = 1; all other outputs = 0.
- In all other cases every control output is 0.
- FSM states RUN (`wait_state`=0) and WAIT (`wait_state`=1):
  - RUN -> WAIT when `frz`=1.
  - WAIT -> RUN when `frz`=0, either because `mem_ready`=1, or because of timeout, or because `mem_req` dropped.
  - `wait_cnt` (8-bit, internal) gets `wait_cnt`+1 when `frz`=1, otherwise 0.
- Timeout: `mem_err` = `mem_req` & !`mem_ready` & (`wait_cnt` == `TIMEOUT`).
  - The pipeline advances that cycle and the access is dropped (no write-back of load data is guaranteed).
  - The FSM returns to RUN and `wait_cnt` becomes 0.
- Counters:
  - `stall_cnt` increments in every cycle with `pc_hold`=1.
  - `flush_cnt` increments in every cycle with `if_id_flush`=1.
  - Both saturate at 2^CW-1 and never wrap.

## Timing
- All hold, flush and bubble outputs, and `mem_err`, are combinational from current inputs and `wait_cnt`. They take effect at the next rising edge of `clk`.
- Reset values:
  - `wait_cnt`=0, state RUN, `stall_cnt`=0, `flush_cnt`=0.
  - All control outputs and `mem_err` are forced to 0 while `rst`=1, regardless of inputs.
- Reset mid-WAIT: the FSM goes to RUN and `wait_cnt` to 0 asynchronously; the counters clear.
- Load-use costs exactly 1 cycle:
  - Cycle N: `lu`=1, so the bubble enters ID/EX at the edge.
  - Cycle N+1: `MemRead_id_ex`=0, so `lu`=0 and the dependent instruction proceeds.
- A jump costs 2 cycles: IF/ID is flushed and ID/EX is bubbled at the same edge.
- A memory wait costs exactly k freeze cycles, where k is the number of cycles with `mem_ready`=0 (k ≤ `TIMEOUT`).
- A timeout costs `TIMEOUT` freeze cycles, followed by 1 `mem_err` cycle.

## Test plan
- Load-use: lw x5 in EX (`MemRead_id_ex`=1, `Rd_id_ex`=5) with `Rs2_id`=5, `rs2_used_id`=1 -> 1 cycle of `load_use_flag`=`pc_hold`=`if_id_hold`=1, then all 0; `stall_cnt`=1.
- x0 and unused operands: `Rd_id_ex`=0 with `Rs1_id`=0 -> no stall. `Rs1_id`=5 with `rs1_used_id`=0 -> no stall.
- Jump with simultaneous load-use: `jump_flag`=1 and `lu`=1 -> `if_id_flush`=1, `load_use_flag`=1, `pc_hold`=0; `flush_cnt`=1.
- Memory wait: `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1 -> 3 cycles of full freeze with `wait_state`=1 for cycles 2-3; `jump_flag` held high throughout is acted on only in cycle 4.
- Timeout with `TIMEOUT`=4: `mem_ready` stuck at 0 -> 4 freeze cycles, then `mem_err`=1 for 1 cycle with no freeze; `wait_state`=0 afterwards; `stall_cnt`=4.
- Async reset asserted during WAIT with `wait_cnt`=2 -> outputs 0 immediately; after release, `wait_state`=0, counters 0, and a new 2-cycle wait freezes exactly 2 cycles.
